darkdma: RTL



---
 rtl/darkdma_pkg.sv | 14 +
 rtl/darkdma_timer.sv | 28 ++
 rtl/darkdma.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/darkdma_pkg.sv
// Shared types and constants for the darkdma word-copy engine.
package darkdma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [3:0]  BE_WORD   = 4'hF;
    localparam logic [31:0] ADDR_STEP = 32'd4;

endpackage

// File: rtl/darkdma_timer.sv
// Wait-state counter for a bus initiator: counts cycles an access spends
// unacknowledged and flags the cycle in which the count reaches TIMEOUT.
module darkdma_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic XCLK,
    input  logic XRES,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [16:0] cnt;

    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 17'd1;
        end
    end

    // Fires during the TIMEOUT-th unacknowledged cycle, so the access drops next cycle.
    assign expired = en && ((cnt + 17'd1) == 17'(TIMEOUT));

endmodule

// File: rtl/darkdma.sv
// Word-copy DMA initiator: reads LEN words from SRC and writes them to DST,
// one read then one write per word, with a per-access wait-state timeout.
module darkdma
    import darkdma_pkg::*;
#(
    parameter int LENW    = 16,
    parameter int TIMEOUT = 64
) (
    input  logic            XCLK,
    input  logic            XRES,
    input  logic            START,
    input  logic            ABORT,
    input  logic [31:0]     SRC,
    input  logic [31:0]     DST,
    input  logic [LENW-1:0] LEN,
    output logic            BUSY,
    output logic            DONE,
    output logic            ERR,
    output logic            BUS_EN,
    output logic            BUS_RE,
    output logic            BUS_WE,
    output logic [3:0]      BUS_BE,
    output logic [31:0]     BUS_ADDR,
    output logic [31:0]     BUS_WDATA,
    input  logic [31:0]     BUS_RDATA,
    input  logic            BUS_RACK,
    input  logic            BUS_WACK
);

    state_t          state, state_n;
    logic [31:0]     src, dst, hold;
    logic [31:0]     src_n, dst_n, hold_n;
    logic [LENW-1:0] rem, rem_n;
    logic            err_n;
    logic            expired, ack, tmr_clr, tmr_en;

    logic            en_n, re_n, we_n, busy_n, done_n;
    logic [3:0]      be_n;
    logic [31:0]     addr_n, wdata_n;

    assign tmr_en  = (state == RD) || (state == WR);
    assign ack     = BUS_EN && (((state == RD) && BUS_RACK) || ((state == WR) && BUS_WACK));
    assign tmr_clr = ack || (state_n != state);

    darkdma_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .XCLK    (XCLK),
        .XRES    (XRES),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (expired)
    );

    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            hold      <= '0;
            rem       <= '0;
            ERR       <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            BUS_EN    <= 1'b0;
            BUS_RE    <= 1'b0;
            BUS_WE    <= 1'b0;
            BUS_BE    <= '0;
            BUS_ADDR  <= '0;
            BUS_WDATA <= '0;
        end else begin
            state     <= state_n;
            src       <= src_n;
            dst       <= dst_n;
            hold      <= hold_n;
            rem       <= rem_n;
            ERR       <= err_n;
            BUSY      <= busy_n;
            DONE      <= done_n;
            BUS_EN    <= en_n;
            BUS_RE    <= re_n;
            BUS_WE    <= we_n;
            BUS_BE    <= be_n;
            BUS_ADDR  <= addr_n;
            BUS_WDATA <= wdata_n;
        end
    end

    // Priority inside an access: ABORT, then timeout, then ack.
    always_comb begin
        state_n = state;
        src_n   = src;
        dst_n   = dst;
        hold_n  = hold;
        rem_n   = rem;
        err_n   = ERR;
        case (state)
            IDLE: begin
                if (START) begin
                    err_n = 1'b0;
                    if (LEN != '0) begin
                        src_n   = SRC & ~32'h3;
                        dst_n   = DST & ~32'h3;
                        rem_n   = LEN;
                        state_n = RD;
                    end else begin
                        state_n = FIN;
                    end
                end
            end
            RD: begin
                if (ABORT) begin
                    state_n = IDLE;
                end else if (expired) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (ack) begin
                    hold_n  = BUS_RDATA;
                    state_n = WR;
                end
            end
            WR: begin
                if (ABORT) begin
                    state_n = IDLE;
                end else if (expired) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else if (ack) begin
                    src_n   = src + ADDR_STEP;
                    dst_n   = dst + ADDR_STEP;
                    rem_n   = rem - LENW'(1);
                    state_n = (rem == LENW'(1)) ? FIN : RD;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state and next address/data values.
    always_comb begin
        re_n    = (state_n == RD);
        we_n    = (state_n == WR);
        en_n    = re_n || we_n;
        busy_n  = en_n;
        done_n  = (state_n == FIN);
        be_n    = we_n ? BE_WORD : 4'h0;
        addr_n  = re_n ? src_n : (we_n ? dst_n : 32'h0);
        wdata_n = we_n ? hold_n : 32'h0;
    end

endmodule
